fir_seq_ctrl: RTL and testbench
===============================

# fir_seq_ctrl

Compute sequencer for the FIR engine. Owns the single read/write port of the data BRAM and the read port of the tap BRAM, and keeps an 11-entry circular sample history in the data BRAM. Accepts samples on AXI-Stream slave, runs one multiply-accumulate per tap, and emits one result per sample on AXI-Stream master. Framed by ap_start/ap_done from the AXI-Lite config block; tap writes stay with the config block and never overlap a run.

## Interface
- pADDR_WIDTH, 12, BRAM byte-address width
- pDATA_WIDTH, 32, sample/tap/result width (signed)
- Tape_Num, 11, number of taps and history depth
- axis_clk  in  1  clock
- axis_rst_n  in  1  asynchronous active-low reset
- ap_start  in  1  one-cycle start pulse, honoured only in IDLE
- data_length  in  32  samples per run, sampled at ap_start
- ap_idle  out  1  high only in IDLE
- ap_done  out  1  one-cycle pulse when run completes
- ss_tvalid / ss_tdata / ss_tlast  in  1 / pDATA_WIDTH / 1  input stream (ss_tlast ignored)
- ss_tready  out  1  input accept
- sm_tvalid / sm_tdata / sm_tlast  out  1 / pDATA_WIDTH / 1  output stream
- sm_tready  in  1  output accept
- tap_EN  out  1  tap BRAM read enable
- tap_A  out  pADDR_WIDTH  tap byte address (k*4)
- tap_Do  in  pDATA_WIDTH  tap read data, valid 1 cycle after tap_EN
- data_EN / data_WE  out  1 / 1  data BRAM enable / write
- data_A  out  pADDR_WIDTH  data byte address (slot*4)
- data_Di  out  pDATA_WIDTH  write data
- data_Do  in  pDATA_WIDTH  read data, valid 1 cycle after read

## Operation
- States: IDLE, CLEAR, WAIT_IN, MAC, ACC, OUT, DONE.
- IDLE: ap_idle=1. ap_start -> latch data_length, cnt=0, wr_ptr=0, slot=0 -> CLEAR.
- CLEAR: write 0 to slots 0..Tape_Num-1, one per cycle (Tape_Num cycles). Then WAIT_IN if data_length!=0, else DONE.
- WAIT_IN: ss_tready=1. On ss_tvalid&&ss_tready: data_WE=1, data_A=wr_ptr*4, data_Di=ss_tdata; acc<=0; k<=0 -> MAC.
- MAC: for k=0..Tape_Num-1, one per cycle: tap_EN=1, tap_A=k*4; data_EN=1, data_WE=0, data_A=((wr_ptr-k) mod Tape_Num)*4. From second MAC cycle, acc += tap_Do*data_Do for previous k. After k=Tape_Num-1 -> ACC.
- ACC: accumulate last product -> OUT.
- OUT: sm_tvalid=1, sm_tdata=acc, sm_tlast=(cnt==data_length-1). On sm_tready: cnt++, wr_ptr = (wr_ptr==Tape_Num-1)?0:wr_ptr+1; then DONE if cnt+1==data_length else WAIT_IN.
- DONE: ap_done=1 one cycle -> IDLE.
- Arithmetic: signed pDATA_WIDTH x pDATA_WIDTH product, truncated to low pDATA_WIDTH bits; accumulator wraps modulo 2^pDATA_WIDTH, no saturation.
- y[n] = sum_{k=0}^{Tape_Num-1} tap[k]*x[n-k], x[m<0]=0 within a run.

## Timing
- Reset values: ap_idle=1, every other output 0 (ss_tready, sm_tvalid, sm_tdata, sm_tlast, ap_done, tap_EN, tap_A, data_EN, data_WE, data_A, data_Di); state IDLE, acc/cnt/wr_ptr=0.
- Input handshake at cycle T: MAC T+1..T+11, ACC T+12, sm_tvalid from T+13. Min sample period 14 cycles (sm_tready held high).
- ss_tready is 0 outside WAIT_IN; at most one sample in flight.
- sm_tvalid held, sm_tdata/sm_tlast stable, until sm_tready; no new input accepted meanwhile.
- ap_start outside IDLE ignored; data_length changes mid-run ignored.
- Reset mid-run: immediate return to IDLE, all outputs to reset values, partial result discarded; BRAM contents untouched (next CLEAR zeroes history).
- Tap BRAM is read-only here; tap_EN=0 outside MAC.

## Test plan
- Impulse: taps 1..11, data_length=12, x=1,0,...,0 -> y=1,2,...,11,0; sm_tlast only on 12th; ap_done one pulse after last handshake; ap_idle returns 1.
- Wrap-around: taps 1..11, data_length=25, x[n]=n+1 -> matches golden model incl. outputs after wr_ptr 10->0.
- Overflow: tap0=0x7FFFFFFF, others 0, x=2 -> y=0xFFFFFFFE; tap0=-3, x=5 -> y=0xFFFFFFF1.
- Backpressure: sm_tready low 5 cycles in OUT -> sm_tdata stable, ss_tready=0, no data_WE; resumes with next sample correct.
- data_length=0: ap_start -> 11 CLEAR writes of 0, ap_done, no sm_tvalid, ss_tready never 1.
- Reset during MAC, then new run with taps 1..11, x=5 -> first y=5 (history cleared, no stale samples).

Source files
------------

// File: rtl/fir_seq_ctrl_if.sv
// rtl/fir_seq_ctrl_if.sv - stream and BRAM port bundle for the FIR compute sequencer
interface fir_seq_ctrl_if #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
);
    logic                   ss_tvalid;
    logic [pDATA_WIDTH-1:0] ss_tdata;
    logic                   ss_tlast;
    logic                   ss_tready;

    logic                   sm_tvalid;
    logic [pDATA_WIDTH-1:0] sm_tdata;
    logic                   sm_tlast;
    logic                   sm_tready;

    logic                   tap_EN;
    logic [pADDR_WIDTH-1:0] tap_A;
    logic [pDATA_WIDTH-1:0] tap_Do;

    logic                   data_EN;
    logic                   data_WE;
    logic [pADDR_WIDTH-1:0] data_A;
    logic [pDATA_WIDTH-1:0] data_Di;
    logic [pDATA_WIDTH-1:0] data_Do;

    modport master (
        input  ss_tvalid, ss_tdata, ss_tlast, sm_tready, tap_Do, data_Do,
        output ss_tready, sm_tvalid, sm_tdata, sm_tlast,
               tap_EN, tap_A, data_EN, data_WE, data_A, data_Di
    );

    modport slave (
        output ss_tvalid, ss_tdata, ss_tlast, sm_tready, tap_Do, data_Do,
        input  ss_tready, sm_tvalid, sm_tdata, sm_tlast,
               tap_EN, tap_A, data_EN, data_WE, data_A, data_Di
    );
endinterface

// File: rtl/fir_seq_ctrl.sv
// rtl/fir_seq_ctrl.sv - FIR compute sequencer: sample history, tap MAC loop, result stream
module fir_seq_ctrl #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic          axis_clk,
    input  logic          axis_rst_n,
    input  logic          ap_start,
    input  logic [31:0]   data_length,
    output logic          ap_idle,
    output logic          ap_done,
    fir_seq_ctrl_if.master bus
);
    localparam int IW = $clog2(Tape_Num);
    localparam logic [IW-1:0] LAST_IDX = IW'(Tape_Num - 1);
    localparam logic [IW-1:0] DEPTH    = IW'(Tape_Num);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_WAIT_IN, S_MAC, S_ACC, S_OUT, S_DONE
    } state_t;

    state_t                 state, state_nx;
    logic [31:0]            len_q;
    logic [31:0]            cnt;
    logic [IW-1:0]          wr_ptr;
    logic [IW-1:0]          idx;
    logic [IW-1:0]          rd_slot;
    logic [pDATA_WIDTH-1:0] acc;
    logic [pDATA_WIDTH-1:0] prod;
    logic                   last_sample;
    logic                   ss_hs;
    logic                   sm_hs;

    logic                   ss_tready_c, sm_tvalid_c, sm_tlast_c;
    logic [pDATA_WIDTH-1:0] sm_tdata_c, data_Di_c;
    logic                   tap_EN_c, data_EN_c, data_WE_c;
    logic [pADDR_WIDTH-1:0] tap_A_c, data_A_c;

    logic                   unused_ss_tlast;
    assign unused_ss_tlast = bus.ss_tlast;

    function automatic logic [pADDR_WIDTH-1:0] word_addr(input logic [IW-1:0] w);
        return {{(pADDR_WIDTH-IW-2){1'b0}}, w, 2'b00};
    endfunction

    // idx is the clear slot in CLEAR and the tap index in MAC
    always_comb begin
        if (wr_ptr >= idx) rd_slot = wr_ptr - idx;
        else               rd_slot = wr_ptr + (DEPTH - idx);
    end

    assign prod        = pDATA_WIDTH'($signed(bus.tap_Do) * $signed(bus.data_Do));
    assign last_sample = (cnt + 32'd1 == len_q);
    assign ss_hs       = (state == S_WAIT_IN) && bus.ss_tvalid;
    assign sm_hs       = (state == S_OUT) && bus.sm_tready;

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) state <= S_IDLE;
        else             state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        ap_idle     = 1'b0;
        ap_done     = 1'b0;
        ss_tready_c = 1'b0;
        sm_tvalid_c = 1'b0;
        sm_tdata_c  = '0;
        sm_tlast_c  = 1'b0;
        tap_EN_c    = 1'b0;
        tap_A_c     = '0;
        data_EN_c   = 1'b0;
        data_WE_c   = 1'b0;
        data_A_c    = '0;
        data_Di_c   = '0;
        case (state)
            S_IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) state_nx = S_CLEAR;
            end
            S_CLEAR: begin
                data_EN_c = 1'b1;
                data_WE_c = 1'b1;
                data_A_c  = word_addr(idx);
                if (idx == LAST_IDX) state_nx = (len_q != 32'd0) ? S_WAIT_IN : S_DONE;
            end
            S_WAIT_IN: begin
                ss_tready_c = 1'b1;
                if (bus.ss_tvalid) begin
                    data_EN_c = 1'b1;
                    data_WE_c = 1'b1;
                    data_A_c  = word_addr(wr_ptr);
                    data_Di_c = bus.ss_tdata;
                    state_nx  = S_MAC;
                end
            end
            S_MAC: begin
                tap_EN_c  = 1'b1;
                tap_A_c   = word_addr(idx);
                data_EN_c = 1'b1;
                data_A_c  = word_addr(rd_slot);
                if (idx == LAST_IDX) state_nx = S_ACC;
            end
            S_ACC: state_nx = S_OUT;
            S_OUT: begin
                sm_tvalid_c = 1'b1;
                sm_tdata_c  = acc;
                sm_tlast_c  = last_sample;
                if (bus.sm_tready) state_nx = last_sample ? S_DONE : S_WAIT_IN;
            end
            S_DONE: begin
                ap_done  = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // BRAM read data lags the address by one cycle, so each MAC cycle adds the previous tap's product
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            len_q  <= '0;
            cnt    <= '0;
            wr_ptr <= '0;
            idx    <= '0;
            acc    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ap_start) begin
                        len_q  <= data_length;
                        cnt    <= '0;
                        wr_ptr <= '0;
                        idx    <= '0;
                    end
                end
                S_CLEAR: idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                S_WAIT_IN: begin
                    if (ss_hs) begin
                        acc <= '0;
                        idx <= '0;
                    end
                end
                S_MAC: begin
                    if (idx != '0) acc <= acc + prod;
                    idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                end
                S_ACC: acc <= acc + prod;
                S_OUT: begin
                    if (sm_hs) begin
                        cnt    <= cnt + 32'd1;
                        wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ss_tready = ss_tready_c;
    assign bus.sm_tvalid = sm_tvalid_c;
    assign bus.sm_tdata  = sm_tdata_c;
    assign bus.sm_tlast  = sm_tlast_c;
    assign bus.tap_EN    = tap_EN_c;
    assign bus.tap_A     = tap_A_c;
    assign bus.data_EN   = data_EN_c;
    assign bus.data_WE   = data_WE_c;
    assign bus.data_A    = data_A_c;
    assign bus.data_Di   = data_Di_c;
endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb/tb_fir_seq_ctrl.sv - self-checking bench for fir_seq_ctrl
module tb_fir_seq_ctrl;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int NT = 11;

    logic          axis_clk    = 1'b0;
    logic          axis_rst_n  = 1'b0;
    logic          ap_start    = 1'b0;
    logic [31:0]   data_length = '0;
    logic          ap_idle;
    logic          ap_done;

    fir_seq_ctrl_if #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) bus();

    fir_seq_ctrl #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(NT)) dut (
        .axis_clk    (axis_clk),
        .axis_rst_n  (axis_rst_n),
        .ap_start    (ap_start),
        .data_length (data_length),
        .ap_idle     (ap_idle),
        .ap_done     (ap_done),
        .bus         (bus)
    );

    always #5 axis_clk = ~axis_clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] tap_ram [0:15];
    logic [31:0] dmem    [0:15];
    int wr_total   = 0;
    int wr_nonzero = 0;
    int smv_cyc    = 0;
    int ssr_cyc    = 0;

    always @(posedge axis_clk) begin
        if (bus.data_EN) begin
            if (bus.data_WE) dmem[bus.data_A[5:2]] <= bus.data_Di;
            else             bus.data_Do <= dmem[bus.data_A[5:2]];
        end
        if (bus.tap_EN) bus.tap_Do <= tap_ram[bus.tap_A[5:2]];
    end

    always @(posedge axis_clk) begin
        if (axis_rst_n) begin
            if (bus.data_EN && bus.data_WE) begin
                wr_total <= wr_total + 1;
                if (bus.data_Di != 0) wr_nonzero <= wr_nonzero + 1;
            end
            if (bus.sm_tvalid) smv_cyc <= smv_cyc + 1;
            if (bus.ss_tready) ssr_cyc <= ssr_cyc + 1;
        end
    end

    logic [31:0] taps [NT];
    logic [31:0] xs [$];
    logic [31:0] last_y;

    typedef struct {
        logic [31:0] tap0;
        logic [31:0] x;
        logic [31:0] y;
    } ovf_vec_t;
    ovf_vec_t ovf [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Convolution of the whole run's input sequence; samples before the run start are zero
    function automatic logic [31:0] model_y(input int n);
        logic [31:0] s = '0;
        for (int k = 0; k < NT; k++)
            if (n - k >= 0) s = s + taps[k] * xs[n-k];
        return s;
    endfunction

    task automatic run_fir(input int len, input int bp, input bit disturb);
        int wr0, nz0, smv0, ssr0, lat, t;
        for (int k = 0; k < NT; k++) tap_ram[k] = taps[k];
        wr0 = wr_total; nz0 = wr_nonzero; smv0 = smv_cyc; ssr0 = ssr_cyc;
        @(negedge axis_clk); ap_start = 1'b1; data_length = len;
        @(negedge axis_clk); ap_start = 1'b0; data_length = $urandom;
        for (int n = 0; n < len; n++) begin
            t = 0;
            while (!bus.ss_tready && t < 200) begin @(negedge axis_clk); t++; end
            if (!bus.ss_tready) begin chk("ss_tready_timeout", 32'd0, 32'd1); return; end
            bus.ss_tvalid = 1'b1; bus.ss_tdata = xs[n]; bus.ss_tlast = (n == len - 1);
            @(negedge axis_clk);
            bus.ss_tvalid = 1'b0; bus.ss_tdata = $urandom; bus.ss_tlast = 1'b0;
            lat = 1;
            while (!bus.sm_tvalid && lat < 200) begin
                ap_start = disturb && (lat == 5);
                @(negedge axis_clk);
                lat++;
            end
            ap_start = 1'b0;
            chk("result_latency", 32'(lat), 32'd13);
            if (!bus.sm_tvalid) return;
            last_y = bus.sm_tdata;
            chk("sm_tdata", bus.sm_tdata, model_y(n));
            chk("sm_tlast", 32'(bus.sm_tlast), 32'(n == len - 1));
            for (int s = 0; s < bp; s++) begin
                @(negedge axis_clk);
                chk("bp_tvalid", 32'(bus.sm_tvalid), 32'd1);
                chk("bp_tdata", bus.sm_tdata, model_y(n));
                chk("bp_ss_tready", 32'(bus.ss_tready), 32'd0);
                chk("bp_data_WE", 32'(bus.data_WE), 32'd0);
            end
            bus.sm_tready = 1'b1;
            @(negedge axis_clk);
            bus.sm_tready = 1'b0;
            if (n != len - 1) chk("ap_done_early", 32'(ap_done), 32'd0);
        end
        if (len == 0) begin
            t = 0;
            while (!ap_done && t < 100) begin @(negedge axis_clk); t++; end
        end
        chk("ap_done", 32'(ap_done), 32'd1);
        @(negedge axis_clk);
        chk("ap_done_pulse", 32'(ap_done), 32'd0);
        chk("ap_idle_after", 32'(ap_idle), 32'd1);
        chk("bram_writes", 32'(wr_total - wr0), 32'(NT + len));
        chk("sm_tvalid_cycles", 32'(smv_cyc - smv0), 32'(len * (bp + 1)));
        chk("ss_tready_cycles", 32'(ssr_cyc - ssr0), 32'(len));
        if (len == 0) chk("clear_nonzero_writes", 32'(wr_nonzero - nz0), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ap_idle"},   32'(ap_idle),       32'd1);
        chk({tag, "_ap_done"},   32'(ap_done),       32'd0);
        chk({tag, "_ss_tready"}, 32'(bus.ss_tready), 32'd0);
        chk({tag, "_sm_tvalid"}, 32'(bus.sm_tvalid), 32'd0);
        chk({tag, "_sm_tdata"},  bus.sm_tdata,       32'd0);
        chk({tag, "_sm_tlast"},  32'(bus.sm_tlast),  32'd0);
        chk({tag, "_tap_EN"},    32'(bus.tap_EN),    32'd0);
        chk({tag, "_tap_A"},     32'(bus.tap_A),     32'd0);
        chk({tag, "_data_EN"},   32'(bus.data_EN),   32'd0);
        chk({tag, "_data_WE"},   32'(bus.data_WE),   32'd0);
        chk({tag, "_data_A"},    32'(bus.data_A),    32'd0);
        chk({tag, "_data_Di"},   bus.data_Di,        32'd0);
    endtask

    task automatic set_ramp_taps();
        for (int k = 0; k < NT; k++) taps[k] = 32'(k + 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        ovf[0] = '{tap0: 32'h7FFF_FFFF, x: 32'd2,         y: 32'hFFFF_FFFE};
        ovf[1] = '{tap0: 32'hFFFF_FFFD, x: 32'd5,         y: 32'hFFFF_FFF1};
        ovf[2] = '{tap0: 32'h8000_0000, x: 32'd2,         y: 32'h0000_0000};
        ovf[3] = '{tap0: 32'hFFFF_FFFF, x: 32'hFFFF_FFFF, y: 32'h0000_0001};
        ovf[4] = '{tap0: 32'h0001_0000, x: 32'h0001_0003, y: 32'h0003_0000};

        bus.ss_tvalid = 1'b0; bus.ss_tdata = '0; bus.ss_tlast = 1'b0; bus.sm_tready = 1'b0;
        repeat (3) @(negedge axis_clk);
        check_idle_outputs("reset");
        axis_rst_n = 1'b1;
        @(negedge axis_clk);
        check_idle_outputs("post_reset");

        // Impulse response reads the taps back in order
        set_ramp_taps();
        xs = {};
        xs.push_back(32'd1);
        for (int i = 1; i < 12; i++) xs.push_back(32'd0);
        run_fir(12, 0, 1'b0);
        chk("impulse_last_y", last_y, 32'd0);

        // History wraps twice past slot 10
        xs = {};
        for (int i = 0; i < 25; i++) xs.push_back(32'(i + 1));
        run_fir(25, 0, 1'b0);

        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < NT; k++) taps[k] = '0;
            taps[0] = ovf[i].tap0;
            xs = {};
            xs.push_back(ovf[i].x);
            run_fir(1, 0, 1'b0);
            chk("ovf_table", last_y, ovf[i].y);
        end

        set_ramp_taps();
        xs = {};
        for (int i = 0; i < 4; i++) xs.push_back($urandom_range(0, 1000));
        run_fir(4, 5, 1'b0);

        xs = {};
        run_fir(0, 0, 1'b0);
        for (int s = 0; s < NT; s++) chk("cleared_slot", dmem[s], 32'd0);

        for (int r = 0; r < 4; r++) begin
            int len;
            for (int k = 0; k < NT; k++) taps[k] = $urandom;
            len = $urandom_range(1, 20);
            xs = {};
            for (int i = 0; i < len; i++) xs.push_back($urandom);
            run_fir(len, $urandom_range(0, 3), 1'b1);
        end

        // Abort a run in the middle of its MAC loop, leaving stale samples behind
        set_ramp_taps();
        for (int k = 0; k < NT; k++) tap_ram[k] = taps[k];
        @(negedge axis_clk); ap_start = 1'b1; data_length = 32'd2;
        @(negedge axis_clk); ap_start = 1'b0;
        t = 0;
        while (!bus.ss_tready && t < 200) begin @(negedge axis_clk); t++; end
        bus.ss_tvalid = 1'b1; bus.ss_tdata = 32'd77;
        @(negedge axis_clk);
        bus.ss_tvalid = 1'b0;
        repeat (3) @(negedge axis_clk);
        chk("pre_reset_in_mac", 32'(bus.tap_EN), 32'd1);
        axis_rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        @(negedge axis_clk);
        axis_rst_n = 1'b1;
        xs = {};
        xs.push_back(32'd5);
        run_fir(1, 0, 1'b0);
        chk("after_reset_y", last_y, 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
